// File: rtl/vga_fetch_scheduler_if.sv
// CPU peripheral bus and framebuffer SRAM port that the VGA fetch scheduler arbitrates.
// The scheduler is the slave of the CPU side and drives the SRAM port.
interface vga_fetch_scheduler_if #(
   parameter int ADDR_W = 4
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_ack;
   logic [31:0]       cpu_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vga_fetch_scheduler.sv
// Shares one single-port framebuffer SRAM between CPU accesses and a once-per-line
// row prefetch, and produces the registered 1-bit cell pixel for the output stage.
module vga_fetch_scheduler #(
   parameter int ADDR_W   = 4,
   parameter int FETCH_HI = 38
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] x_hi,
   input  logic [4:0] x_lo,
   input  logic [4:0] y_hi,
   input  logic [5:0] y_lo,
   input  logic       blank,
   output logic       pixel,
   vga_fetch_scheduler_if.slave bus
);
   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_DISP_RD    = 2'd1;
   localparam logic [1:0] S_CPU_RD     = 2'd2;
   localparam logic [1:0] S_CPU_WR_ACK = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        fetch_pending_q, fetch_pending_d;
   logic [31:0] fetch_buf_q, fetch_buf_d;
   logic [31:0] active_buf_q, active_buf_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        pixel_q, pixel_d;

   logic fetch_slot;
   logic vblank;
   logic line_start;
   logic fetch_want;
   logic grant_disp;
   logic timing_unused;

   assign fetch_slot    = (x_hi == 6'(FETCH_HI)) && (x_lo == 5'd0);
   assign vblank        = (y_hi >= 5'd16);
   assign line_start    = (x_hi == 6'd0) && (x_lo == 5'd0);
   // The slot itself counts as a request so a CPU access raised on that cycle loses.
   assign fetch_want    = fetch_pending_q | (fetch_slot & ~vblank);
   assign timing_unused = ^y_lo;

   // Grant decision; the SRAM strobes are driven straight from it.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      state_d       = state_q;
      grant_disp    = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (rst_n) begin
         case (state_q)
            S_IDLE: begin
               if (fetch_want) begin
                  grant_disp   = 1'b1;
                  bus.mem_en   = 1'b1;
                  bus.mem_addr = y_hi[ADDR_W-1:0];
                  state_d      = S_DISP_RD;
               end else if (bus.cpu_req && !cpu_ack_q) begin
                  // While its ack is showing, the requester's held cpu_req is the old request.
                  bus.mem_en   = 1'b1;
                  bus.mem_we   = bus.cpu_we;
                  bus.mem_addr = bus.cpu_addr;
                  if (bus.cpu_we) begin
                     bus.mem_wdata = bus.cpu_wdata;
                     state_d       = S_CPU_WR_ACK;
                  end else begin
                     state_d       = S_CPU_RD;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      fetch_pending_d = fetch_pending_q;
      if (grant_disp) begin
         fetch_pending_d = 1'b0;
      end else if (fetch_slot && !vblank) begin
         fetch_pending_d = 1'b1;
      end

      fetch_buf_d = fetch_buf_q;
      if (state_q == S_DISP_RD) begin
         fetch_buf_d = bus.mem_rdata;
      end else if (fetch_slot && vblank) begin
         fetch_buf_d = '0;
      end

      cpu_ack_d    = (state_q == S_CPU_RD) || (state_q == S_CPU_WR_ACK);
      cpu_rdata_d  = (state_q == S_CPU_RD) ? bus.mem_rdata : cpu_rdata_q;
      active_buf_d = line_start ? fetch_buf_q : active_buf_q;
      pixel_d      = active_buf_q[x_hi[4:0]] & ~blank;
   end

   // NOTE: reset is synchronous and also clears the row buffers, so a reset line shows black.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         fetch_pending_q <= 1'b0;
         fetch_buf_q     <= '0;
         active_buf_q    <= '0;
         cpu_rdata_q     <= '0;
         cpu_ack_q       <= 1'b0;
         pixel_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         state_q         <= state_d;
         fetch_pending_q <= fetch_pending_d;
         fetch_buf_q     <= fetch_buf_d;
         active_buf_q    <= active_buf_d;
         cpu_rdata_q     <= cpu_rdata_d;
         cpu_ack_q       <= cpu_ack_d;
         pixel_q         <= pixel_d;
      end
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign pixel         = pixel_q;
endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Self-checking bench for vga_fetch_scheduler: scanline timing plus directed and random
// CPU traffic, compared every cycle against a transaction-level reference model.
module tb_vga_fetch_scheduler;
   localparam int ADDR_W   = 4;
   localparam int FETCH_HI = 38;
   localparam int LINE_LEN = 42 * 32;
   localparam int Y_UPD    = 1048;
   localparam int N_LINES  = 17 * 48;
   localparam int ACK_MAX  = 20;

   typedef struct {
      int                start;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } op_t;

   typedef struct {
      int          at;
      bit          is_fb;
      bit          rd;
      logic [31:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] x_hi;
   logic [4:0] x_lo;
   logic [4:0] y_hi;
   logic [5:0] y_lo;
   logic       blank;
   logic       pixel;

   vga_fetch_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

   vga_fetch_scheduler #(.ADDR_W(ADDR_W), .FETCH_HI(FETCH_HI)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x_hi  (x_hi),
      .x_lo  (x_lo),
      .y_hi  (y_hi),
      .y_lo  (y_lo),
      .blank (blank),
      .pixel (pixel),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Framebuffer SRAM with a preload port used only while reset is held.
   logic [31:0]       sram [16];
   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [31:0]       pre_data;

   always @(posedge clk) begin
      if (pre_we) begin
         sram[pre_addr] <= pre_data;
      end else if (bus.mem_en) begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata      <= sram[bus.mem_addr];
      end
   end

   int errors = 0;
   int checks = 0;

   // Reference model: port occupancy, a pending-fetch flag and timed result events.
   int          cyc = 0;
   int          port_free = 0;
   bit          m_pend = 1'b0;
   bit          m_ack = 1'b0;
   bit          exp_pix = 1'b0;
   logic [31:0] m_fb = '0;
   logic [31:0] m_active = '0;
   logic [31:0] m_rdata = '0;
   logic [31:0] ref_mem [16];
   ev_t         evq [$];

   // CPU-side driver state.
   op_t ops [$];
   op_t cur;
   bit  op_active = 1'b0;
   bit  drop_next = 1'b0;
   int  op_age = 0;
   int  hx = 0;
   int  rst_hx = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int line);
      int                yl;
      bit                slot;
      bit                vb;
      logic              exp_en;
      logic              exp_we;
      logic [ADDR_W-1:0] exp_addr;
      logic [31:0]       exp_wd;

      @(negedge clk);
      yl    = (hx >= Y_UPD) ? (line + 1) % N_LINES : line % N_LINES;
      x_hi  = 6'(hx / 32);
      x_lo  = 5'(hx % 32);
      y_hi  = 5'(yl / 48);
      y_lo  = 6'(yl % 48);
      blank = (hx >= 1024) || (yl >= 768);
      rst_n = (hx != rst_hx);

      if (!rst_n) begin
         bus.cpu_req = 1'b0;
         op_active   = 1'b0;
         drop_next   = 1'b0;
      end else if (drop_next) begin
         bus.cpu_req = 1'b0;
         drop_next   = 1'b0;
      end else if (!op_active && ops.size() > 0 && hx >= ops[0].start) begin
         cur           = ops.pop_front();
         bus.cpu_req   = 1'b1;
         bus.cpu_we    = cur.we;
         bus.cpu_addr  = cur.addr;
         bus.cpu_wdata = cur.data;
         op_active     = 1'b1;
         op_age        = 0;
      end

      m_ack = 1'b0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
         if (evq[i].at == cyc) begin
            if (evq[i].is_fb) begin
               m_fb = evq[i].val;
            end else begin
               m_ack = 1'b1;
               if (evq[i].rd) m_rdata = evq[i].val;
            end
            evq.delete(i);
         end
      end

      slot     = (hx == FETCH_HI * 32);
      vb       = (yl >= 768);
      exp_en   = 1'b0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      if (rst_n) begin
         if (cyc >= port_free && (m_pend || (slot && !vb))) begin
            exp_en   = 1'b1;
            exp_addr = y_hi[ADDR_W-1:0];
            evq.push_back('{at: cyc + 2, is_fb: 1'b1, rd: 1'b0, val: ref_mem[exp_addr]});
            m_pend    = 1'b0;
            port_free = cyc + 2;
         end else begin
            if (slot && !vb) m_pend = 1'b1;
            if (cyc >= port_free && bus.cpu_req && !m_ack) begin
               exp_en   = 1'b1;
               exp_we   = bus.cpu_we;
               exp_addr = bus.cpu_addr;
               if (bus.cpu_we) begin
                  exp_wd             = bus.cpu_wdata;
                  ref_mem[exp_addr]  = bus.cpu_wdata;
               end
               evq.push_back('{at: cyc + 2, is_fb: 1'b0, rd: !bus.cpu_we, val: ref_mem[exp_addr]});
               port_free = cyc + 2;
            end
         end
         if (slot && vb) evq.push_back('{at: cyc + 1, is_fb: 1'b1, rd: 1'b0, val: 32'd0});
      end

      #1;
      check("mem_en", 32'(bus.mem_en), 32'(exp_en));
      check("mem_we", 32'(bus.mem_we), 32'(exp_we));
      check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      check("mem_wdata", bus.mem_wdata, exp_wd);
      check("cpu_ack", 32'(bus.cpu_ack), 32'(m_ack));
      check("cpu_rdata", bus.cpu_rdata, m_rdata);
      check("pixel", 32'(pixel), 32'(exp_pix));

      if (!rst_n) begin
         evq.delete();
         m_pend    = 1'b0;
         m_fb      = '0;
         m_active  = '0;
         m_rdata   = '0;
         exp_pix   = 1'b0;
         port_free = cyc + 1;
      end else begin
         exp_pix = m_active[x_hi[4:0]] & !blank;
         if (hx == 0) m_active = m_fb;
      end

      if (op_active) begin
         op_age++;
         if (bus.cpu_ack === 1'b1) begin
            op_active = 1'b0;
            drop_next = 1'b1;
         end else if (op_age > ACK_MAX) begin
            check("cpu_ack_timeout", 32'(op_age), 32'(ACK_MAX));
            op_active = 1'b0;
            drop_next = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic run_line(input int line);
      for (int h = 0; h < LINE_LEN; h++) begin
         hx = h;
         tick(line);
      end
   endtask

   initial begin
      op_t o;
      int  s;
      int  l;

      rst_n         = 1'b0;
      x_hi          = '0;
      x_lo          = '0;
      y_hi          = '0;
      y_lo          = '0;
      blank         = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      pre_we        = 1'b1;
      pre_addr      = '0;
      pre_data      = '0;

      for (int i = 0; i < 16; i++) begin
         pre_addr   = ADDR_W'(i);
         pre_data   = (i == 3) ? 32'h8000_0001 : $urandom;
         ref_mem[i] = pre_data;
         @(negedge clk);
      end
      pre_we = 1'b0;

      @(negedge clk);
      #1;
      check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
      check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_pixel", 32'(pixel), 32'd0);

      // Prefetch row 3, then display it while writing and reading back address 5.
      run_line(3 * 48 - 1);
      ops.push_back('{start: 100, we: 1'b1, addr: 4'd5, data: 32'hDEAD_BEEF});
      ops.push_back('{start: 110, we: 1'b0, addr: 4'd5, data: 32'd0});
      run_line(3 * 48);

      // CPU read raised on the fetch slot itself waits behind the display read.
      ops.push_back('{start: FETCH_HI * 32, we: 1'b0, addr: 4'd7, data: 32'd0});
      run_line(3 * 48 + 1);

      // Write to the row on screen mid-line, and a CPU read granted just before the slot.
      ops.push_back('{start: 500, we: 1'b1, addr: 4'd3, data: 32'h0000_FFFF});
      ops.push_back('{start: FETCH_HI * 32 - 1, we: 1'b0, addr: 4'd2, data: 32'd0});
      run_line(3 * 48 + 2);
      run_line(3 * 48 + 3);

      // Vertical blank at the slot clears the prefetch; the next line must be black.
      run_line(16 * 48 - 1);
      run_line(200);

      // Reset while a CPU read is in flight, then a normal read afterwards.
      ops.push_back('{start: 300, we: 1'b0, addr: 4'd3, data: 32'd0});
      ops.push_back('{start: 400, we: 1'b0, addr: 4'd5, data: 32'd0});
      rst_hx = 301;
      run_line(201);
      rst_hx = -1;

      for (int k = 0; k < 6; k++) begin
         l = $urandom_range(0, N_LINES - 1);
         s = $urandom_range(0, 200);
         repeat (4) begin
            o.start = s;
            o.we    = 1'($urandom);
            o.addr  = ADDR_W'($urandom);
            o.data  = $urandom;
            ops.push_back(o);
            s += $urandom_range(3, 250);
         end
         o.start = FETCH_HI * 32 - 4 + $urandom_range(0, 8);
         o.we    = 1'($urandom);
         o.addr  = ADDR_W'($urandom);
         o.data  = $urandom;
         ops.push_back(o);
         run_line(l);
      end

      run_line(300);
      check("ops_drained", 32'(ops.size()) + 32'(op_active), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
